puf_seq_ctrl: RTL and testbench



---
 rtl/puf_seq_ctrl_if.sv | 27 ++
 rtl/puf_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_puf_seq_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/puf_seq_ctrl_if.sv
// Host and PUF-cell signals of the PUF sequencer, named from the sequencer's side.
// master: the sequencer; slave: the host/PUF cell environment.
interface puf_seq_ctrl_if #(
    parameter int N_BITS = 8
);
    logic              start_i;
    logic [7:0]        seed_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [N_BITS-1:0] resp_word_o;
    logic [7:0]        puf_chall_o;
    logic              puf_en_o;
    logic              puf_rst_o;
    logic              puf_resp_i;
    logic              puf_finish_i;

    modport master (
        input  start_i, seed_i, puf_resp_i, puf_finish_i,
        output busy_o, done_o, err_o, resp_word_o, puf_chall_o, puf_en_o, puf_rst_o
    );

    modport slave (
        output start_i, seed_i, puf_resp_i, puf_finish_i,
        input  busy_o, done_o, err_o, resp_word_o, puf_chall_o, puf_en_o, puf_rst_o
    );
endinterface

// File: rtl/puf_seq_ctrl.sv
// Drives one PUF bit cell through N_BITS challenges derived from a seed and
// shifts each arbiter response into a response word.
module puf_seq_ctrl #(
    parameter int N_BITS  = 8,
    parameter int CLR_CYC = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic           clk,
    input  logic           rst,
    puf_seq_ctrl_if.master bus
);
    // state   | meaning
    // IDLE    | waiting for start, cell held in reset
    // CLEAR   | cell held in reset for CLR_CYC cycles with the challenge applied
    // RUN     | oscillators enabled, waiting for arbiter finish or timeout
    // CAPTURE | shift the captured bit into the word, pick the next challenge
    // DONE    | one-cycle done pulse, then back to IDLE
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam int CW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int IW = $clog2(N_BITS);

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     clr_cnt_q, clr_cnt_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic [7:0]        seed_q, seed_d;
    logic [7:0]        chall_q, chall_d;
    logic [N_BITS-1:0] word_q, word_d;
    logic              bit_q, bit_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              en_q, en_d;
    logic              prst_q, prst_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            clr_cnt_q <= '0;
            to_cnt_q  <= '0;
            seed_q    <= '0;
            chall_q   <= '0;
            word_q    <= '0;
            bit_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            en_q      <= 1'b0;
            prst_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            clr_cnt_q <= clr_cnt_d;
            to_cnt_q  <= to_cnt_d;
            seed_q    <= seed_d;
            chall_q   <= chall_d;
            word_q    <= word_d;
            bit_q     <= bit_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            en_q      <= en_d;
            prst_q    <= prst_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        clr_cnt_d = clr_cnt_q;
        to_cnt_d  = to_cnt_q;
        seed_d    = seed_q;
        chall_d   = chall_q;
        word_d    = word_q;
        bit_d     = bit_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    seed_d    = bus.seed_i;
                    chall_d   = bus.seed_i;
                    idx_d     = '0;
                    clr_cnt_d = '0;
                    word_d    = '0;
                    err_d     = 1'b0;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == CW'(CLR_CYC - 1)) begin
                    to_cnt_d = '0;
                    state_d  = S_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + CW'(1);
                end
            end
            S_RUN: begin
                // A finish on the last allowed cycle still wins over the abort.
                if (bus.puf_finish_i) begin
                    bit_d   = bus.puf_resp_i;
                    state_d = S_CAPTURE;
                end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            S_CAPTURE: begin
                word_d = {word_q[N_BITS-2:0], bit_q};
                if (idx_q == IW'(N_BITS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d     = idx_q + IW'(1);
                    chall_d   = seed_q + 8'(idx_q) + 8'd1;
                    clr_cnt_d = '0;
                    state_d   = S_CLEAR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        en_d   = (state_d == S_RUN);
        prst_d = (state_d != S_RUN);
    end

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.resp_word_o = word_q;
    assign bus.puf_chall_o = chall_q;
    assign bus.puf_en_o    = en_q;
    assign bus.puf_rst_o   = prst_q;
endmodule

// File: tb/tb_puf_seq_ctrl.sv
// Randomised bench for puf_seq_ctrl: a run-level timeline model predicts every
// output on every cycle, and a PUF cell model answers the sequencer.
module tb_puf_seq_ctrl;
    localparam int N_BITS  = 8;
    localparam int CLR_CYC = 2;
    localparam int TIMEOUT = 1023;
    localparam int NEVER   = 1 << 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    puf_seq_ctrl_if #(.N_BITS(N_BITS)) bus ();

    puf_seq_ctrl #(
        .N_BITS (N_BITS),
        .CLR_CYC(CLR_CYC),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              busy;
        logic              done;
        logic              err;
        logic              en;
        logic              prst;
        logic [7:0]        chall;
        logic [N_BITS-1:0] word;
    } exp_t;

    exp_t exp_q[$];
    exp_t idle_s;
    exp_t cmp_x;
    int   dly_q[$];
    int   dly_plan[N_BITS];
    logic key[256];
    bit   chk_en;
    int   checks;
    int   errors;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp_v);
        end
    endfunction

    function automatic exp_t reset_vals();
        exp_t r;
        r.busy = 1'b0; r.done = 1'b0; r.err = 1'b0;
        r.en = 1'b0; r.prst = 1'b1; r.chall = 8'h00; r.word = '0;
        return r;
    endfunction

    // Per-cycle comparison against the predicted timeline, or the idle state once it drains.
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() > 0) cmp_x = exp_q.pop_front();
            else                  cmp_x = idle_s;
            chk("busy",      bus.busy_o,      cmp_x.busy);
            chk("done",      bus.done_o,      cmp_x.done);
            chk("err",       bus.err_o,       cmp_x.err);
            chk("puf_en",    bus.puf_en_o,    cmp_x.en);
            chk("puf_rst",   bus.puf_rst_o,   cmp_x.prst);
            chk("puf_chall", bus.puf_chall_o, cmp_x.chall);
            chk("resp_word", bus.resp_word_o, cmp_x.word);
            chk("en_rst_excl", bus.puf_en_o & bus.puf_rst_o, 1'b0);
        end
    end

    // PUF cell: finishes d cycles after en rises (d from the plan), responds key[challenge].
    int cur_d;
    int en_cnt;
    bit en_prev;
    always @(posedge clk) begin
        #1;
        if (bus.puf_en_o) begin
            if (!en_prev) begin
                cur_d  = (dly_q.size() > 0) ? dly_q.pop_front() : NEVER;
                en_cnt = 0;
            end else begin
                en_cnt++;
            end
            bus.puf_finish_i = (en_cnt == cur_d);
        end else begin
            bus.puf_finish_i = 1'($urandom_range(0, 1));
        end
        en_prev = bus.puf_en_o;
        bus.puf_resp_i = key[bus.puf_chall_o];
    end

    // Builds the whole expected timeline of one run and asserts start (call at posedge+1 in IDLE).
    task automatic launch(input logic [7:0] seed);
        exp_t              e;
        logic [N_BITS-1:0] w;
        logic [7:0]        ch;
        bit                ab;
        int                run_len;
        exp_q.push_back(idle_s);
        w  = '0;
        ab = 1'b0;
        ch = seed;
        for (int i = 0; i < N_BITS && !ab; i++) begin
            ch = seed + 8'(i);
            e.busy = 1'b1; e.done = 1'b0; e.err = 1'b0; e.chall = ch; e.word = w;
            e.en = 1'b0; e.prst = 1'b1;
            repeat (CLR_CYC) exp_q.push_back(e);
            dly_q.push_back(dly_plan[i]);
            run_len = (dly_plan[i] < TIMEOUT) ? dly_plan[i] + 1 : TIMEOUT;
            e.en = 1'b1; e.prst = 1'b0;
            repeat (run_len) exp_q.push_back(e);
            e.en = 1'b0; e.prst = 1'b1;
            if (dly_plan[i] >= TIMEOUT) begin
                ab = 1'b1; e.done = 1'b1; e.err = 1'b1;
                exp_q.push_back(e);
            end else begin
                exp_q.push_back(e);
                w = {w[N_BITS-2:0], key[ch]};
            end
        end
        if (!ab) begin
            e.busy = 1'b1; e.done = 1'b1; e.err = 1'b0; e.en = 1'b0; e.prst = 1'b1;
            e.chall = ch; e.word = w;
            exp_q.push_back(e);
        end
        idle_s = e;
        idle_s.busy = 1'b0;
        idle_s.done = 1'b0;
        bus.start_i = 1'b1;
        bus.seed_i  = seed;
    endtask

    task automatic finish_run(input bit noisy, output int lat, output int en_cyc, output int dn);
        int cyc;
        lat = -1; en_cyc = 0; dn = 0; cyc = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (exp_q.size() == 0) break;
            if (cyc > 5000) begin
                chk("run_drain_bound", 32'(cyc), 32'd5000);
                break;
            end
            bus.start_i = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noisy) bus.seed_i = 8'($urandom);
            if (bus.puf_en_o) en_cyc++;
            if (bus.done_o) begin
                dn++;
                if (lat < 0) lat = cyc;
            end
        end
        bus.start_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
        $fatal(1, "watchdog");
    end

    int lat, en_cyc, dn, waited;

    initial begin
        checks = 0; errors = 0; chk_en = 1'b0;
        bus.start_i = 1'b0; bus.seed_i = 8'h00;
        bus.puf_resp_i = 1'b0; bus.puf_finish_i = 1'b0;
        for (int c = 0; c < 256; c++) key[c] = c[0];
        idle_s = reset_vals();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_puf_rst", bus.puf_rst_o, 1'b1);
        chk("rst_word", bus.resp_word_o, 8'h00);
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Seed FE, finish 5 cycles after en rises, response = challenge bit 0.
        for (int i = 0; i < N_BITS; i++) dly_plan[i] = 5;
        launch(8'hFE);
        finish_run(1'b0, lat, en_cyc, dn);
        chk("fe_word", bus.resp_word_o, 8'b0101_0101);
        chk("fe_last_chall", bus.puf_chall_o, 8'h05);
        chk("fe_done_pulses", 32'(dn), 32'd1);
        chk("fe_err", bus.err_o, 1'b0);

        // Immediate finish: done lands N_BITS*(CLR_CYC+2)+1 cycles after start.
        for (int i = 0; i < N_BITS; i++) dly_plan[i] = 0;
        launch(8'h3C);
        finish_run(1'b1, lat, en_cyc, dn);
        chk("latency", 32'(lat), 32'd33);

        // Finish never comes on the first challenge: abort after exactly TIMEOUT RUN cycles.
        dly_plan[0] = NEVER;
        launch(8'h21);
        finish_run(1'b0, lat, en_cyc, dn);
        chk("to_en_cycles", 32'(en_cyc), 32'd1023);
        chk("to_err", bus.err_o, 1'b1);
        chk("to_word", bus.resp_word_o, 8'h00);
        chk("to_done_pulses", 32'(dn), 32'd1);

        // Abort after three captured bits (back to back, clears err), word unpadded.
        dly_plan[0] = 0; dly_plan[1] = 1; dly_plan[2] = 2; dly_plan[3] = NEVER;
        launch(8'h11);
        finish_run(1'b0, lat, en_cyc, dn);
        chk("partial_word", bus.resp_word_o, 8'b0000_0101);

        // Finish on the very cycle the timeout would fire: bit kept, no error.
        for (int i = 0; i < N_BITS; i++) dly_plan[i] = 1;
        dly_plan[3] = TIMEOUT - 1;
        launch(8'h80);
        finish_run(1'b1, lat, en_cyc, dn);
        chk("tie_err", bus.err_o, 1'b0);
        chk("tie_word", bus.resp_word_o, 8'b0101_0101);

        // Reset held 3 cycles in the middle of RUN.
        for (int i = 0; i < N_BITS; i++) dly_plan[i] = 10;
        launch(8'h42);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        waited = 0;
        while (!bus.puf_en_o && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("reach_run", bus.puf_en_o, 1'b1);
        @(posedge clk); #1;
        chk_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_busy", bus.busy_o, 1'b0);
        chk("mid_rst_en", bus.puf_en_o, 1'b0);
        chk("mid_rst_prst", bus.puf_rst_o, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        dly_q.delete();
        idle_s = reset_vals();
        @(posedge clk); #1;
        chk("post_rst_word", bus.resp_word_o, 8'h00);
        chk("post_rst_done", bus.done_o, 1'b0);
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Random runs: random key, seeds, finish delays, occasional abort,
        // spurious starts while busy, back-to-back or gapped launches.
        for (int c = 0; c < 256; c++) key[c] = 1'($urandom);
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N_BITS; i++) dly_plan[i] = $urandom_range(0, 6);
            if ($urandom_range(0, 12) == 0) dly_plan[$urandom_range(0, N_BITS - 1)] = NEVER;
            if ($urandom_range(0, 8) == 0) dly_plan[$urandom_range(0, N_BITS - 1)] = TIMEOUT - 1;
            launch(8'($urandom));
            finish_run(1'b1, lat, en_cyc, dn);
            chk("rand_done_pulses", 32'(dn), 32'd1);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                end
            end
        end

        repeat (4) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
